// File: rtl/noc_inj_pkg.sv
// noc_inj_pkg: shared flit width, scheduler state encoding and index helper
package noc_inj_pkg;

    localparam int FLIT_W = 20;

    typedef enum logic [2:0] {IDLE, SELECT, ARM, STREAM, WAIT, DRAIN, DONE} sched_state_t;

    function automatic int wrap_inc(input int v, input int n);
        return (v + 1 == n) ? 0 : v + 1;
    endfunction

endpackage

// File: rtl/inj_out_fifo.sv
// inj_out_fifo: small synchronous FIFO with occupancy count; pop is ignored when empty
module inj_out_fifo
    import noc_inj_pkg::*;
#(
    parameter int WIDTH = FLIT_W,
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_data,
    output logic                     valid,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    rd_ptr, wr_ptr;
    logic             full, do_push, do_pop;

    assign valid    = count != '0;
    assign full     = count == CW'(DEPTH);
    assign do_pop   = pop && valid;
    assign do_push  = push && (!full || do_pop);
    assign pop_data = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (do_pop) rd_ptr <= rd_ptr + AW'(1);
            count <= count + CW'(do_push) - CW'(do_pop);
        end

endmodule

// File: rtl/inj_burst_scheduler.sv
// inj_burst_scheduler: round-robin burst sequencing of NUM_SRC ROM injectors
// onto one output stream through a credit-checked output FIFO.
module inj_burst_scheduler
    import noc_inj_pkg::*;
#(
    parameter int NUM_SRC        = 4,
    parameter int WIDTH          = FLIT_W,
    parameter int SRC_DEPTH      = 30,
    parameter int BURST_LEN      = 8,
    parameter int OUT_FIFO_DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    output logic [NUM_SRC-1:0]         src_enable,
    input  logic [NUM_SRC*WIDTH-1:0]   src_data,
    input  logic [NUM_SRC-1:0]         src_valid,
    output logic [WIDTH-1:0]           out_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [$clog2(NUM_SRC)-1:0] cur_src,
    output logic                       busy,
    output logic                       all_done,
    output logic                       proto_err
);

    localparam int SW = $clog2(NUM_SRC);
    localparam int CW = $clog2(SRC_DEPTH + 1);
    localparam int BW = $clog2(BURST_LEN + 1);
    localparam int FW = $clog2(OUT_FIFO_DEPTH) + 1;

    sched_state_t     state;
    logic [SW-1:0]    ptr, sel_idx;
    logic             sel_found;
    logic [BW-1:0]    issued;
    logic [CW-1:0]    issued_total [NUM_SRC];
    logic [CW-1:0]    accepted     [NUM_SRC];
    logic [NUM_SRC-1:0] armed, exhausted, grant_oh;
    logic             inflight, issue, push, spurious, burst_end;
    logic [FW-1:0]    fifo_count;

    for (genvar i = 0; i < NUM_SRC; i++) begin : g_exh
        assign exhausted[i] = int'(accepted[i]) == SRC_DEPTH;
    end

    // Credit counts the word already in flight so a landing push can never overflow.
    assign grant_oh   = NUM_SRC'(1) << cur_src;
    assign issue      = state == STREAM
                        && int'(fifo_count) + int'(inflight) < OUT_FIFO_DEPTH
                        && int'(issued) < BURST_LEN
                        && int'(issued_total[cur_src]) < SRC_DEPTH;
    assign burst_end  = int'(issued) + int'(issue) == BURST_LEN
                        || int'(issued_total[cur_src]) + int'(issue) == SRC_DEPTH;
    assign src_enable = (state == ARM || issue) ? grant_oh : '0;
    assign push       = src_valid[cur_src] && inflight;
    assign spurious   = |(src_valid & ~grant_oh) || (src_valid[cur_src] && !inflight);
    assign busy       = !(state inside {IDLE, DONE});

    // Iterate backwards so the last hit is the first candidate at or after ptr.
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = ptr;
        for (int k = NUM_SRC - 1; k >= 0; k--)
            if (!exhausted[(int'(ptr) + k) % NUM_SRC]) begin
                sel_found = 1'b1;
                sel_idx   = SW'((int'(ptr) + k) % NUM_SRC);
            end
    end

    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            state     <= IDLE;
            ptr       <= '0;
            cur_src   <= '0;
            issued    <= '0;
            armed     <= '0;
            inflight  <= 1'b0;
            proto_err <= 1'b0;
            all_done  <= 1'b0;
            for (int i = 0; i < NUM_SRC; i++) begin
                issued_total[i] <= '0;
                accepted[i]     <= '0;
            end
        end else begin
            if (spurious) proto_err <= 1'b1;
            if (push) accepted[cur_src] <= accepted[cur_src] + CW'(1);
            if (issue) begin
                inflight              <= 1'b1;
                issued                <= issued + BW'(1);
                issued_total[cur_src] <= issued_total[cur_src] + CW'(1);
            end else if (push) begin
                inflight <= 1'b0;
            end
            case (state)
                IDLE:   if (start) state <= SELECT;
                SELECT: if (!sel_found) state <= DRAIN;
                        else begin
                            cur_src <= sel_idx;
                            issued  <= '0;
                            state   <= armed[sel_idx] ? STREAM : ARM;
                        end
                ARM: begin
                    armed[cur_src] <= 1'b1;
                    state          <= STREAM;
                end
                STREAM: if (burst_end) state <= WAIT;
                WAIT:   if (!inflight) begin
                            ptr   <= SW'(wrap_inc(int'(cur_src), NUM_SRC));
                            state <= SELECT;
                        end
                DRAIN:  if (!out_valid) begin
                            all_done <= 1'b1;
                            state    <= DONE;
                        end
                default: ;
            endcase
        end

    inj_out_fifo #(.WIDTH(WIDTH), .DEPTH(OUT_FIFO_DEPTH)) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (src_data[int'(cur_src)*WIDTH +: WIDTH]),
        .pop       (out_ready),
        .pop_data  (out_data),
        .valid     (out_valid),
        .count     (fifo_count)
    );

endmodule

// File: tb/tb_inj_burst_scheduler.sv
// tb_inj_burst_scheduler: ROM buffer models plus a flit-order reference queue
module tb_inj_burst_scheduler;

    localparam int NS = 4;
    localparam int W  = 20;
    localparam int SD = 30;
    localparam int BL = 8;

    logic              clk = 1'b0;
    logic              rst, start, out_ready, spur;
    logic [NS-1:0]     src_enable, src_valid;
    logic [NS*W-1:0]   src_data;
    logic [W-1:0]      out_data;
    logic              out_valid, busy, all_done, proto_err;
    logic [1:0]        cur_src;

    logic [NS-1:0]     bv;
    logic [W-1:0]      bd [NS];
    int                bidx [NS];
    bit                barm [NS];

    logic [W-1:0]      exp_q [$];
    int                total = 0;
    int                fails = 0;

    always #5 clk = ~clk;

    inj_burst_scheduler #(
        .NUM_SRC(NS), .WIDTH(W), .SRC_DEPTH(SD), .BURST_LEN(BL), .OUT_FIFO_DEPTH(2)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .src_enable(src_enable),
        .src_data(src_data), .src_valid(src_valid), .out_data(out_data),
        .out_valid(out_valid), .out_ready(out_ready), .cur_src(cur_src),
        .busy(busy), .all_done(all_done), .proto_err(proto_err)
    );

    // ROM buffer: first enable arms, each later enable yields word j+1 tagged with source id
    always @(posedge clk or negedge rst)
        if (!rst) begin
            for (int i = 0; i < NS; i++) begin
                bv[i] <= 1'b0; bd[i] <= '0; bidx[i] <= 0; barm[i] <= 1'b0;
            end
        end else begin
            for (int i = 0; i < NS; i++) begin
                bv[i] <= 1'b0;
                if (src_enable[i]) begin
                    if (!barm[i]) barm[i] <= 1'b1;
                    else if (bidx[i] < SD) begin
                        bv[i]   <= 1'b1;
                        bd[i]   <= W'((i << 8) + bidx[i] + 1);
                        bidx[i] <= bidx[i] + 1;
                    end
                end
            end
        end

    for (genvar i = 0; i < NS; i++) begin : g_data
        assign src_data[i*W +: W] = bd[i];
    end
    assign src_valid = bv | (NS'(spur) << 2);

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        total++;
        assert (obs === exp_v) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    function automatic logic [63:0] outs();
        return 64'({src_enable, out_data, out_valid, cur_src, busy, all_done, proto_err});
    endfunction

    // Round-robin bursts of up to BL words until every source has delivered SD words
    task automatic build_expected();
        int rem [NS];
        exp_q.delete();
        foreach (rem[s]) rem[s] = SD;
        for (int r = 0; r < (SD + BL - 1) / BL; r++)
            for (int s = 0; s < NS; s++) begin
                int k;
                k = rem[s] < BL ? rem[s] : BL;
                for (int j = 0; j < k; j++) exp_q.push_back(W'((s << 8) + (SD - rem[s]) + j + 1));
                rem[s] -= k;
            end
    endtask

    // mode 0: ready always, 1: toggle, 2: random
    task automatic run(input int mode, input int max_flits, input int spur_at, input int busy_at);
        int cyc = 0;
        int got = 0;
        bit stalled = 0;
        logic [W-1:0] held = '0;
        while (cyc < 20000 && got < max_flits && !(exp_q.size() == 0 && all_done)) begin
            @(negedge clk);
            cyc++;
            if (stalled) check("stall_hold", {out_valid, out_data}, {1'b1, held});
            if (cyc == busy_at) check("busy_at_restart", busy, 1);
            if (cyc == spur_at) check("spur_while_src0", cur_src, 0);
            start     = (cyc == 1 || cyc == busy_at);
            spur      = (cyc == spur_at);
            out_ready = mode == 0 ? 1'b1 : mode == 1 ? cyc[0] : 1'($urandom_range(0, 1));
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) check("extra_flit", out_data, 0);
                else check("flit", out_data, exp_q.pop_front());
                got++;
            end
            stalled = out_valid && !out_ready;
            held    = out_data;
        end
        start = 0;
        spur  = 0;
        check("run_timeout", cyc >= 20000, 0);
    endtask

    initial begin
        rst = 0; start = 0; out_ready = 0; spur = 0;
        repeat (3) @(negedge clk);
        check("reset_outputs", outs(), 0);
        rst = 1;
        @(negedge clk);
        check("idle_outputs", outs(), 0);

        build_expected();
        check("model_len", exp_q.size(), NS * SD);
        check("model_src3_last", exp_q[NS*SD-1], 20'h0031E);
        run(0, 1000, 0, 40);
        check("run1_left", exp_q.size(), 0);
        check("run1_done", {all_done, busy, proto_err, out_valid}, 4'b1000);
        repeat (3) @(negedge clk);
        check("done_sticky", {all_done, busy}, 2'b10);

        rst = 0;
        @(negedge clk);
        check("reset_clears_done", outs(), 0);
        rst = 1;
        build_expected();
        run(1, 20, 6, 0);
        check("spur_proto_err", proto_err, 1);
        check("busy_mid_stream", busy, 1);

        rst = 0;
        #1 check("async_reset_outputs", outs(), 0);
        @(negedge clk);
        check("held_reset_outputs", outs(), 0);
        rst = 1;
        @(negedge clk);
        check("post_reset_idle", outs(), 0);

        build_expected();
        run(2, 1000, 0, 0);
        check("run3_left", exp_q.size(), 0);
        check("run3_done", {all_done, busy, proto_err, out_valid}, 4'b1000);

        $display("%0d/%0d checks passed", total - fails, total);
        $finish;
    end

endmodule
